// File: rtl/disp_tmds_enc.sv
// DVI 1.0 TMDS encoder for the pixel clock domain. It expands each colour channel to 8 bits,
// applies transition minimising and DC balancing, and sends control tokens during blanking.
module disp_tmds_enc #(
  parameter int BPC = 5
) (
  input  logic           clk_pix,
  input  logic           rst_pix_n,
  input  logic           disp_hsync,
  input  logic           disp_vsync,
  input  logic           disp_de,
  input  logic [BPC-1:0] disp_r,
  input  logic [BPC-1:0] disp_g,
  input  logic [BPC-1:0] disp_b,
  output logic [9:0]     tmds_ch0,
  output logic [9:0]     tmds_ch1,
  output logic [9:0]     tmds_ch2,
  output logic           tmds_de
);

  if (BPC < 4 || BPC > 8) begin : g_bad_bpc
    $error("disp_tmds_enc: BPC must be in 4..8");
  end

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  typedef struct packed {
    logic [9:0]        sym;
    logic signed [4:0] cnt;
  } enc_t;

  // MSB replication written as a bit map, so that BPC=8 needs no zero-width slice.
  function automatic logic [7:0] expand(input logic [BPC-1:0] c);
    logic [7:0] e;
    e = '0;
    for (int i = 0; i < 8; i++) e[7-i] = c[BPC-1-(i%BPC)];
    return e;
  endfunction

  function automatic logic [8:0] minimise(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1 = '0;
    for (int i = 0; i < 8; i++) n1 = n1 + 4'(d[i]);
    use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  // diff is N1 - N0 = 2*N1 - 8. It is worked out at 6 bits and always fits in 5.
  function automatic enc_t balance(input logic [8:0] qm, input logic signed [4:0] cnt);
    enc_t              r;
    logic [3:0]        n1;
    logic signed [5:0] diff6;
    logic signed [4:0] diff;
    n1 = '0;
    for (int i = 0; i < 8; i++) n1 = n1 + 4'(qm[i]);
    diff6 = $signed({1'b0, n1, 1'b0}) - 6'sd8;
    diff  = diff6[4:0];
    if (cnt == 5'sd0 || diff == 5'sd0) begin
      r.sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      r.cnt = qm[8] ? cnt + diff : cnt - diff;
    end else if ((cnt > 5'sd0 && diff > 5'sd0) || (cnt < 5'sd0 && diff < 5'sd0)) begin
      r.sym = {1'b1, qm[8], ~qm[7:0]};
      r.cnt = cnt - diff + (qm[8] ? 5'sd2 : 5'sd0);
    end else begin
      r.sym = {1'b0, qm[8], qm[7:0]};
      r.cnt = cnt + diff - (qm[8] ? 5'sd0 : 5'sd2);
    end
    return r;
  endfunction

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    case (c)
      2'b01:   return CTRL_01;
      2'b10:   return CTRL_10;
      2'b11:   return CTRL_11;
      default: return CTRL_00;
    endcase
  endfunction

  // Channel order: 0 = blue, 1 = green, 2 = red.
  logic [BPC-1:0]    colour [3];
  logic [8:0]        qm_d   [3];
  logic [8:0]        qm_q   [3];
  logic              de_s1, hsync_s1, vsync_s1;
  enc_t              enc    [3];
  logic [9:0]        sym_q  [3];
  logic signed [4:0] cnt_q  [3];

  assign colour[0] = disp_b;
  assign colour[1] = disp_g;
  assign colour[2] = disp_r;

  always_comb begin
    for (int ch = 0; ch < 3; ch++) qm_d[ch] = minimise(expand(colour[ch]));
  end

  // NOTE: pipeline registers use non-blocking assignments, so each stage sees the values its neighbour held before the edge.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      for (int ch = 0; ch < 3; ch++) qm_q[ch] <= '0;
      de_s1    <= 1'b0;
      hsync_s1 <= 1'b0;
      vsync_s1 <= 1'b0;
    end else begin
      for (int ch = 0; ch < 3; ch++) qm_q[ch] <= qm_d[ch];
      de_s1    <= disp_de;
      hsync_s1 <= disp_hsync;
      vsync_s1 <= disp_vsync;
    end
  end

  always_comb begin
    for (int ch = 0; ch < 3; ch++) enc[ch] = balance(qm_q[ch], cnt_q[ch]);
  end

  // Blanking clears the disparity, so every active run starts balanced.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      for (int ch = 0; ch < 3; ch++) begin
        sym_q[ch] <= CTRL_00;
        cnt_q[ch] <= '0;
      end
      tmds_de <= 1'b0;
    end else begin
      tmds_de <= de_s1;
      if (de_s1) begin
        for (int ch = 0; ch < 3; ch++) begin
          sym_q[ch] <= enc[ch].sym;
          cnt_q[ch] <= enc[ch].cnt;
        end
      end else begin
        for (int ch = 0; ch < 3; ch++) cnt_q[ch] <= '0;
        sym_q[0] <= ctrl_token({vsync_s1, hsync_s1});
        sym_q[1] <= CTRL_00;
        sym_q[2] <= CTRL_00;
      end
    end
  end

  assign tmds_ch0 = sym_q[0];
  assign tmds_ch1 = sym_q[1];
  assign tmds_ch2 = sym_q[2];

endmodule

// File: tb/tb_disp_tmds_enc.sv
// Self-checking bench for disp_tmds_enc. It compares the DUT against a behavioural TMDS model
// under directed and random stimulus, and decodes each active symbol back to the expanded colour.
module tb_disp_tmds_enc;
  localparam int BPC = 5;
  localparam logic [9:0] TOK00 = 10'b1101010100;

  logic           clk_pix = 1'b0;
  logic           rst_pix_n = 1'b1;
  logic           disp_hsync = 1'b0, disp_vsync = 1'b0, disp_de = 1'b0;
  logic [BPC-1:0] disp_r = '0, disp_g = '0, disp_b = '0;
  logic [9:0]     tmds_ch0, tmds_ch1, tmds_ch2;
  logic           tmds_de;

  disp_tmds_enc #(.BPC(BPC)) dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n),
    .disp_hsync(disp_hsync), .disp_vsync(disp_vsync), .disp_de(disp_de),
    .disp_r(disp_r), .disp_g(disp_g), .disp_b(disp_b),
    .tmds_ch0(tmds_ch0), .tmds_ch1(tmds_ch1), .tmds_ch2(tmds_ch2),
    .tmds_de(tmds_de)
  );

  always #5 clk_pix = ~clk_pix;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h (%0d) exp 0x%0h (%0d)", tag, got, got, exp, exp);
    end
  endtask

  // Reference model state: one captured input stage and the running disparity.
  int             m_cnt [3];
  logic           m_de, m_hs, m_vs;
  logic [BPC-1:0] m_col [3];
  int             exp_sym [3];
  int             exp_d [3];
  logic           exp_de;

  function automatic int expand8(input int c);
    return ((c << (8 - BPC)) | (c >> (2 * BPC - 8))) & 255;
  endfunction

  function automatic int ones8(input int v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += (v >> i) & 1;
    return n;
  endfunction

  function automatic int token(input int c);
    case (c)
      1: return 10'b0010101011;
      2: return 10'b0101010100;
      3: return 10'b1010101011;
      default: return 10'b1101010100;
    endcase
  endfunction

  // Inverse of the DVI encode. It recovers the 8-bit value that a sink would see.
  function automatic int decode(input logic [9:0] s);
    logic [7:0] q, d;
    q    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return int'(d);
  endfunction

  task automatic model_reset();
    m_de = 0; m_hs = 0; m_vs = 0; exp_de = 0;
    for (int ch = 0; ch < 3; ch++) begin
      m_cnt[ch] = 0; m_col[ch] = '0; exp_sym[ch] = TOK00; exp_d[ch] = 0;
    end
  endtask

  // One clock edge of the model: symbols come from the previously captured inputs.
  task automatic model_edge(input logic de, input logic hs, input logic vs,
                            input logic [BPC-1:0] r, input logic [BPC-1:0] g, input logic [BPC-1:0] b);
    int d, n, q, q8, p, n1, n0, sym;
    bit xnor_mode;
    if (m_de) begin
      for (int ch = 0; ch < 3; ch++) begin
        d = expand8(int'(m_col[ch]));
        n = ones8(d);
        xnor_mode = (n > 4) || (n == 4 && (d & 1) == 0);
        // The running parity of d gives the XOR chain. An XNOR chain also inverts odd positions.
        p = 0; q = 0;
        for (int i = 0; i < 8; i++) begin
          p ^= (d >> i) & 1;
          q |= (p ^ (xnor_mode ? (i % 2) : 0)) << i;
        end
        q8 = xnor_mode ? 0 : 1;
        n1 = ones8(q); n0 = 8 - n1;
        if (m_cnt[ch] == 0 || n1 == n0) begin
          sym = ((1 - q8) << 9) | (q8 << 8) | (q8 ? q : (~q & 255));
          m_cnt[ch] += q8 ? (n1 - n0) : (n0 - n1);
        end else if ((m_cnt[ch] > 0 && n1 > n0) || (m_cnt[ch] < 0 && n0 > n1)) begin
          sym = 512 | (q8 << 8) | (~q & 255);
          m_cnt[ch] += 2 * q8 + (n0 - n1);
        end else begin
          sym = (q8 << 8) | q;
          m_cnt[ch] += (n1 - n0) - 2 * (1 - q8);
        end
        exp_sym[ch] = sym;
        exp_d[ch]   = d;
      end
    end else begin
      for (int ch = 0; ch < 3; ch++) m_cnt[ch] = 0;
      exp_sym[0] = token({30'b0, m_vs, m_hs});
      exp_sym[1] = TOK00;
      exp_sym[2] = TOK00;
    end
    exp_de = m_de;
    m_de = de; m_hs = hs; m_vs = vs;
    m_col[0] = b; m_col[1] = g; m_col[2] = r;
  endtask

  // Called just after a falling edge. It drives the inputs, steps one clock and compares at the next falling edge.
  task automatic cycle(input logic de, input logic hs, input logic vs,
                       input logic [BPC-1:0] r, input logic [BPC-1:0] g, input logic [BPC-1:0] b);
    logic [9:0] obs [3];
    int c;
    disp_de = de; disp_hsync = hs; disp_vsync = vs;
    disp_r = r; disp_g = g; disp_b = b;
    @(posedge clk_pix);
    model_edge(de, hs, vs, r, g, b);
    @(negedge clk_pix);
    obs[0] = tmds_ch0; obs[1] = tmds_ch1; obs[2] = tmds_ch2;
    check("tmds_de", int'(tmds_de), int'(exp_de));
    for (int ch = 0; ch < 3; ch++) begin
      check($sformatf("sym_ch%0d", ch), int'(obs[ch]), exp_sym[ch]);
      if (exp_de) check($sformatf("decode_ch%0d", ch), decode(obs[ch]), exp_d[ch]);
      c = int'(dut.cnt_q[ch]);
      check($sformatf("cnt_bound_ch%0d", ch), int'(c <= 10 && c >= -10), 1);
    end
  endtask

  task automatic blank(input logic hs, input logic vs, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, hs, vs, '0, '0, '0);
  endtask

  initial begin
    int hits, first, d2;
    model_reset();
    // The reset is asserted between clock edges, so the outputs must change with no clock.
    #1 rst_pix_n = 1'b0;
    #1;
    check("rst_ch0", int'(tmds_ch0), int'(TOK00));
    check("rst_de", int'(tmds_de), 0);
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    blank(1'b0, 1'b0, 3);

    // Reset in the middle of a line, between two clock edges.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 5'd7, 5'd19, 5'd26);
    #2 rst_pix_n = 1'b0;
    #1;
    check("midrst_ch0", int'(tmds_ch0), int'(TOK00));
    check("midrst_ch1", int'(tmds_ch1), int'(TOK00));
    check("midrst_ch2", int'(tmds_ch2), int'(TOK00));
    check("midrst_de", int'(tmds_de), 0);
    model_reset();
    @(negedge clk_pix);
    disp_de = 1'b0; disp_hsync = 1'b0; disp_vsync = 1'b0;
    rst_pix_n = 1'b1;
    blank(1'b0, 1'b0, 3);
    check("post_rst_ch0", int'(tmds_ch0), int'(TOK00));

    // Control tokens during blanking.
    blank(1'b1, 1'b0, 3);
    check("tok_hs_ch0", int'(tmds_ch0), 10'b0010101011);
    check("tok_hs_ch1", int'(tmds_ch1), int'(TOK00));
    blank(1'b1, 1'b1, 3);
    check("tok_hv_ch0", int'(tmds_ch0), 10'b1010101011);
    check("tok_hv_ch2", int'(tmds_ch2), int'(TOK00));
    blank(1'b0, 1'b0, 2);

    // Three black pixels starting from cnt = 0.
    cycle(1'b1, 1'b0, 1'b0, '0, '0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0, '0, '0);
    check("blk0_ch1", int'(tmds_ch1), 10'b0100000000);
    check("blk0_cnt", int'(dut.cnt_q[1]), -8);
    cycle(1'b1, 1'b0, 1'b0, '0, '0, '0);
    check("blk1_ch2", int'(tmds_ch2), 10'b1111111111);
    check("blk1_cnt", int'(dut.cnt_q[2]), 2);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, '0);
    check("blk2_ch0", int'(tmds_ch0), 10'b0100000000);
    check("blk2_cnt", int'(dut.cnt_q[0]), -6);
    blank(1'b0, 1'b0, 2);

    // A white pixel: 31 expands to 0xFF.
    cycle(1'b1, 1'b0, 1'b0, 5'd31, 5'd31, 5'd31);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, '0);
    check("white_ch0", int'(tmds_ch0), 10'b1000000000);
    check("white_ch2", int'(tmds_ch2), 10'b1000000000);
    check("white_cnt", int'(dut.cnt_q[1]), -8);
    blank(1'b0, 1'b0, 2);

    // Random lines. The sync inputs also toggle during de, where they must be ignored.
    for (int line = 0; line < 2; line++) begin
      for (int p = 0; p < 2000; p++)
        cycle(1'b1, 1'($urandom), 1'($urandom), BPC'($urandom), BPC'($urandom), BPC'($urandom));
      for (int p = 0; p < 40; p++)
        cycle(1'b0, 1'($urandom), 1'($urandom), BPC'($urandom), BPC'($urandom), BPC'($urandom));
    end

    // A de pulse one cycle long carries exactly one data symbol.
    blank(1'b0, 1'b0, 3);
    cycle(1'b1, 1'b0, 1'b0, 5'd16, BPC'($urandom), BPC'($urandom));
    hits = 0; first = -1; d2 = -1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, '0, '0, '0);
      if (tmds_de) begin
        hits++;
        if (first < 0) begin first = i; d2 = decode(tmds_ch2); end
      end
    end
    check("glitch_de_len", hits, 1);
    check("glitch_de_pos", first, 0);
    check("glitch_ch2_dec", d2, 8'h84);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
